// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative CORDIC engine, rotation and vectoring modes
// One shared micro-rotation datapath per clock, arctangent ROM indexed by the iteration counter.
module cordic_engine #(
  parameter int WORD_LENGTH  = 21,
  parameter int FRAC_BITS    = 16,
  parameter int N_ITERATIONS = 17
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode_i,
  input  logic signed [WORD_LENGTH-1:0] x_i,
  input  logic signed [WORD_LENGTH-1:0] y_i,
  input  logic signed [WORD_LENGTH-1:0] z_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WORD_LENGTH-1:0] x_o,
  output logic signed [WORD_LENGTH-1:0] y_o,
  output logic signed [WORD_LENGTH-1:0] z_o
);

  localparam int WL = WORD_LENGTH;
  localparam int SH = 30 - FRAC_BITS;
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_ITER = CW'(N_ITERATIONS - 1);

  if (WORD_LENGTH < 8 || WORD_LENGTH > 32) begin : g_chk_wl
    $error("cordic_engine: WORD_LENGTH must be in 8..32");
  end
  if (FRAC_BITS < 0 || FRAC_BITS > WORD_LENGTH - 3) begin : g_chk_fb
    $error("cordic_engine: FRAC_BITS must be in 0..WORD_LENGTH-3");
  end
  if (N_ITERATIONS < 1 || N_ITERATIONS > WORD_LENGTH || N_ITERATIONS > 31) begin : g_chk_n
    $error("cordic_engine: N_ITERATIONS must be in 1..min(WORD_LENGTH,31)");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_iter;
  logic                  r_mode;
  logic signed [WL-1:0]  r_x;
  logic signed [WL-1:0]  r_y;
  logic signed [WL-1:0]  r_z;
  logic [31:0]           w_atan_q30;
  logic [31:0]           w_atan_rnd;
  logic signed [WL-1:0]  w_atan;
  logic signed [WL-1:0]  w_x_sh;
  logic signed [WL-1:0]  w_y_sh;
  logic                  w_d;
  logic                  w_in_ready;
  logic                  w_out_valid;

  // atan(2^-i) at 30 fractional bits, rounded to nearest
  always_comb begin
    w_atan_q30 = 32'd0;
    case (r_iter)
      5'd0:  w_atan_q30 = 32'd843314857;  5'd1:  w_atan_q30 = 32'd497837830;
      5'd2:  w_atan_q30 = 32'd263043837;  5'd3:  w_atan_q30 = 32'd133525159;
      5'd4:  w_atan_q30 = 32'd67021687;   5'd5:  w_atan_q30 = 32'd33543516;
      5'd6:  w_atan_q30 = 32'd16775851;   5'd7:  w_atan_q30 = 32'd8388437;
      5'd8:  w_atan_q30 = 32'd4194283;    5'd9:  w_atan_q30 = 32'd2097149;
      5'd10: w_atan_q30 = 32'd1048576;    5'd11: w_atan_q30 = 32'd524288;
      5'd12: w_atan_q30 = 32'd262144;     5'd13: w_atan_q30 = 32'd131072;
      5'd14: w_atan_q30 = 32'd65536;      5'd15: w_atan_q30 = 32'd32768;
      5'd16: w_atan_q30 = 32'd16384;      5'd17: w_atan_q30 = 32'd8192;
      5'd18: w_atan_q30 = 32'd4096;       5'd19: w_atan_q30 = 32'd2048;
      5'd20: w_atan_q30 = 32'd1024;       5'd21: w_atan_q30 = 32'd512;
      5'd22: w_atan_q30 = 32'd256;        5'd23: w_atan_q30 = 32'd128;
      5'd24: w_atan_q30 = 32'd64;         5'd25: w_atan_q30 = 32'd32;
      5'd26: w_atan_q30 = 32'd16;         5'd27: w_atan_q30 = 32'd8;
      5'd28: w_atan_q30 = 32'd4;          5'd29: w_atan_q30 = 32'd2;
      5'd30: w_atan_q30 = 32'd1;
      default: w_atan_q30 = 32'd0;
    endcase
  end

  assign w_atan_rnd = (w_atan_q30 + (32'd1 << (SH - 1))) >> SH;
  assign w_atan     = $signed(WL'(w_atan_rnd));
  assign w_x_sh     = r_x >>> r_iter;
  assign w_y_sh     = r_y >>> r_iter;
  // d=1 is a clockwise step
  assign w_d        = r_mode ? ~r_y[WL-1] : r_z[WL-1];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (r_iter == LAST_ITER) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x    <= x_i;
          r_y    <= y_i;
          r_z    <= z_i;
          r_mode <= mode_i;
          r_iter <= '0;
        end
        S_RUN: begin
          if (w_d) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end
          r_iter <= r_iter + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign x_o       = r_x;
  assign y_o       = r_y;
  assign z_o       = r_z;

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - self-checking bench for cordic_engine against an arithmetic CORDIC model
module tb_cordic_engine;
  localparam int WL = 21, FB = 16, NI = 17;
  localparam int WL2 = 16, FB2 = 12, NI2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, mode_i, out_valid, out_ready;
  logic signed [WL-1:0] x_i, y_i, z_i, x_o, y_o, z_o;
  logic s_in_valid, s_in_ready, s_mode_i, s_out_valid, s_out_ready;
  logic signed [WL2-1:0] s_x_i, s_y_i, s_z_i, s_x_o, s_y_o, s_z_o;

  int n_checks = 0;
  int n_pass = 0;

  cordic_engine #(.WORD_LENGTH(WL), .FRAC_BITS(FB), .N_ITERATIONS(NI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode_i(mode_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .out_valid(out_valid), .out_ready(out_ready),
    .x_o(x_o), .y_o(y_o), .z_o(z_o));

  cordic_engine #(.WORD_LENGTH(WL2), .FRAC_BITS(FB2), .N_ITERATIONS(NI2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode_i(s_mode_i),
    .x_i(s_x_i), .y_i(s_y_i), .z_i(s_z_i), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .x_o(s_x_o), .y_o(s_y_o), .z_o(s_z_o));

  function automatic longint wrap(input longint v, input int wl);
    longint m;
    m = v & ((longint'(1) << wl) - 1);
    if (((m >>> (wl - 1)) & 1) != 0) m = m - (longint'(1) << wl);
    return m;
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint atan_q(input int i, input int fb);
    real t;
    longint tq;
    int s;
    t  = $atan($pow(2.0, -1.0 * i)) * 1073741824.0;
    tq = longint'(t);
    s  = 30 - fb;
    return (tq + (longint'(1) << (s - 1))) >>> s;
  endfunction

  task automatic cordic_model(input int wl, input int fb, input int n, input bit m,
                              input longint x0, input longint y0, input longint z0,
                              output longint xr, output longint yr, output longint zr);
    longint x, y, z, a, xn, yn, zn;
    bit d;
    x = wrap(x0, wl); y = wrap(y0, wl); z = wrap(z0, wl);
    for (int i = 0; i < n; i++) begin
      a = atan_q(i, fb);
      d = m ? (y >= 0) : (z < 0);
      if (d) begin xn = x + (y >>> i); yn = y - (x >>> i); zn = z + a; end
      else   begin xn = x - (y >>> i); yn = y + (x >>> i); zn = z - a; end
      x = wrap(xn, wl); y = wrap(yn, wl); z = wrap(zn, wl);
    end
    xr = x; yr = y; zr = z;
  endtask

  task automatic do_op(input bit m, input longint x, input longint y, input longint z,
                       output int lat, output longint xo, output longint yo, output longint zo);
    @(negedge clk);
    mode_i = m; x_i = x[WL-1:0]; y_i = y[WL-1:0]; z_i = z[WL-1:0]; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; x_i = WL'($urandom); y_i = WL'($urandom); z_i = WL'($urandom);
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!out_valid && lat < 200);
    xo = longint'(x_o); yo = longint'(y_o); zo = longint'(z_o);
  endtask

  task automatic do_op_small(input bit m, input longint x, input longint y, input longint z,
                             output int lat, output longint xo, output longint yo, output longint zo);
    @(negedge clk);
    s_mode_i = m; s_x_i = x[WL2-1:0]; s_y_i = y[WL2-1:0]; s_z_i = z[WL2-1:0]; s_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!s_out_valid && lat < 200);
    xo = longint'(s_x_o); yo = longint'(s_y_o); zo = longint'(s_z_o);
    s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  task automatic release_op;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode_i = 1'b0; x_i = '0; y_i = '0; z_i = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_mode_i = 1'b0; s_x_i = '0; s_y_i = '0; s_z_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++;
    if ({x_o, y_o, z_o} !== '0) $display("FAIL reset_outputs: got %0d %0d %0d want 0 0 0", x_o, y_o, z_o);
    else n_pass++;
    n_checks++;
    if ({s_in_ready, s_out_valid} !== 2'b10) $display("FAIL reset_small_handshake: got %b%b want 10", s_in_ready, s_out_valid);
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_directed(input string nm, input bit m, input longint x, input longint y, input longint z,
                               input longint ex, input longint tx, input longint ey, input longint ty,
                               input longint ez, input longint tz);
    int lat;
    longint xo, yo, zo, mx, my, mz;
    do_op(m, x, y, z, lat, xo, yo, zo);
    cordic_model(WL, FB, NI, m, x, y, z, mx, my, mz);
    n_checks++; if (lat !== NI) $display("FAIL %s_latency: got %0d want %0d", nm, lat, NI); else n_pass++;
    n_checks++;
    if ({xo, yo, zo} !== {mx, my, mz}) $display("FAIL %s_model: got %0d %0d %0d want %0d %0d %0d", nm, xo, yo, zo, mx, my, mz);
    else n_pass++;
    n_checks++; if (labs(xo - ex) > tx) $display("FAIL %s_x_real: got %0d want %0d +-%0d", nm, xo, ex, tx); else n_pass++;
    n_checks++; if (labs(yo - ey) > ty) $display("FAIL %s_y_real: got %0d want %0d +-%0d", nm, yo, ey, ty); else n_pass++;
    if (tz >= 0) begin
      n_checks++; if (labs(zo - ez) > tz) $display("FAIL %s_z_real: got %0d want %0d +-%0d", nm, zo, ez, tz); else n_pass++;
    end
    release_op();
  endtask

  task automatic test_random;
    int lat;
    bit m;
    longint x, y, z, xo, yo, zo, mx, my, mz;
    for (int k = 0; k < 12; k++) begin
      m = 1'($urandom);
      if (!m) begin
        x = longint'($urandom_range(0, 60000)) - 30000;
        y = longint'($urandom_range(0, 60000)) - 30000;
        z = longint'($urandom_range(0, 228000)) - 114000;
      end else begin
        x = longint'($urandom_range(1, 60000));
        y = longint'($urandom_range(0, 120000)) - 60000;
        z = longint'($urandom_range(0, 40000)) - 20000;
      end
      do_op(m, x, y, z, lat, xo, yo, zo);
      cordic_model(WL, FB, NI, m, x, y, z, mx, my, mz);
      n_checks++;
      if (lat !== NI || {xo, yo, zo} !== {mx, my, mz})
        $display("FAIL random_%0d: got lat=%0d %0d %0d %0d want lat=%0d %0d %0d %0d", k, lat, xo, yo, zo, NI, mx, my, mz);
      else n_pass++;
      release_op();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    longint xo, yo, zo, mx, my, mz;
    do_op(1'b0, 39797, 0, 30000, lat, xo, yo, zo);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      if (c == 3) begin mode_i = 1'b1; x_i = 21'sd1234; y_i = 21'sd777; z_i = 21'sd55; end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {longint'(x_o), longint'(y_o), longint'(z_o)} !== {xo, yo, zo})
        $display("FAIL backpressure_hold_%0d: got v=%b r=%b %0d %0d %0d want v=1 r=0 %0d %0d %0d",
                 c, out_valid, in_ready, x_o, y_o, z_o, xo, yo, zo);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL backpressure_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    else n_pass++;
    do_op(1'b1, 40000, -20000, 0, lat, xo, yo, zo);
    cordic_model(WL, FB, NI, 1'b1, 40000, -20000, 0, mx, my, mz);
    n_checks++;
    if (lat !== NI || {xo, yo, zo} !== {mx, my, mz})
      $display("FAIL backpressure_next_op: got lat=%0d %0d %0d %0d want lat=%0d %0d %0d %0d", lat, xo, yo, zo, NI, mx, my, mz);
    else n_pass++;
    release_op();
  endtask

  task automatic test_back_to_back;
    int hits[$];
    longint mx, my, mz;
    cordic_model(WL, FB, NI, 1'b0, 39797, 0, 20000, mx, my, mz);
    @(negedge clk);
    mode_i = 1'b0; x_i = 21'sd39797; y_i = '0; z_i = 21'sd20000; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        hits.push_back(c);
        n_checks++;
        if ({longint'(x_o), longint'(y_o), longint'(z_o)} !== {mx, my, mz})
          $display("FAIL b2b_result_%0d: got %0d %0d %0d want %0d %0d %0d", c, x_o, y_o, z_o, mx, my, mz);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (hits.size() < 3) $display("FAIL b2b_count: got %0d want >=3", hits.size()); else n_pass++;
    for (int k = 1; k < hits.size(); k++) begin
      n_checks++;
      if (hits[k] - hits[k-1] !== NI + 2) $display("FAIL b2b_period_%0d: got %0d want %0d", k, hits[k] - hits[k-1], NI + 2);
      else n_pass++;
    end
    for (int c = 0; c < 40 && !(in_ready && !out_valid); c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_drain: got in_ready=%b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    @(negedge clk);
    mode_i = 1'b0; x_i = 21'sd39797; y_i = '0; z_i = 21'sd51472; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL midrun_handshake: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if ({x_o, y_o, z_o} !== '0) $display("FAIL midrun_outputs: got %0d %0d %0d want 0 0 0", x_o, y_o, z_o);
    else n_pass++;
    rst = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_checks++; if (seen !== 0) $display("FAIL midrun_stale: got %0d results want 0", seen); else n_pass++;
  endtask

  task automatic test_param_sweep;
    int lat;
    longint xo, yo, zo, mx, my, mz, x, z;
    do_op_small(1'b0, 2487, 0, 2145, lat, xo, yo, zo);
    cordic_model(WL2, FB2, NI2, 1'b0, 2487, 0, 2145, mx, my, mz);
    n_checks++; if (lat !== NI2) $display("FAIL sweep_latency: got %0d want %0d", lat, NI2); else n_pass++;
    n_checks++;
    if ({xo, yo, zo} !== {mx, my, mz}) $display("FAIL sweep_model: got %0d %0d %0d want %0d %0d %0d", xo, yo, zo, mx, my, mz);
    else n_pass++;
    n_checks++; if (labs(xo - 3547) > 4) $display("FAIL sweep_x_real: got %0d want 3547 +-4", xo); else n_pass++;
    n_checks++; if (labs(yo - 2048) > 4) $display("FAIL sweep_y_real: got %0d want 2048 +-4", yo); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      x = longint'($urandom_range(1, 3000));
      z = longint'($urandom_range(0, 14000)) - 7000;
      do_op_small(1'b0, x, 0, z, lat, xo, yo, zo);
      cordic_model(WL2, FB2, NI2, 1'b0, x, 0, z, mx, my, mz);
      n_checks++;
      if (lat !== NI2 || {xo, yo, zo} !== {mx, my, mz})
        $display("FAIL sweep_random_%0d: got lat=%0d %0d %0d %0d want lat=%0d %0d %0d %0d", k, lat, xo, yo, zo, NI2, mx, my, mz);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed("rot_pi4", 1'b0, 39797, 0, 51472, 46341, 8, 46341, 8, 0, 4);
    test_directed("vec_45", 1'b1, 65536, 65536, 0, 152626, 16, 0, 8, 51472, 4);
    test_directed("rot_neg", 1'b0, 39797, 0, -102944, 0, 8, -65536, 8, 0, -1);
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Iterative, parametrised CORDIC core with two modes: rotation (sin/cos, polar-to-rect) and vectoring (magnitude/atan2, rect-to-polar).
- Performs one micro-rotation per clock using a single shared datapath.
- Holds its own arctangent ROM and iteration counter.
- Sits between a valid/ready producer and a valid/ready consumer in the verification datapath, and supersedes per-stage external sequencing.

Parameters:
- WORD_LENGTH, 21: signed width of x, y, z. Range 8..32.
- FRAC_BITS, 16: fractional bits of x, y, z (angles in radians). Constraint: FRAC_BITS <= WORD_LENGTH-3.
- N_ITERATIONS, 17: micro-rotations per operation. Range 1..min(WORD_LENGTH, 31).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  engine can accept operands.
- mode_i  input  1  0 = rotation, 1 = vectoring; captured at the input handshake.
- x_i  input  WORD_LENGTH  signed operand x.
- y_i  input  WORD_LENGTH  signed operand y.
- z_i  input  WORD_LENGTH  signed operand z (angle).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- x_o  output  WORD_LENGTH  signed result x.
- y_o  output  WORD_LENGTH  signed result y.
- z_o  output  WORD_LENGTH  signed result z.

Behaviour:
- **Reset:** rst sampled low at a rising edge forces state IDLE, clears the iteration counter and zeroes x_o, y_o, z_o. After reset, out_valid=0 and in_ready=1.
- **Reset mid-operation:** an operation in RUN or DONE is discarded; no out_valid is produced for it.
- **States:**
  - IDLE: in_ready=1, out_valid=0. If in_valid=1, register x, y, z and mode, set i=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Perform one micro-rotation per cycle, i = 0..N_ITERATIONS-1. After the i=N_ITERATIONS-1 update, go to DONE.
  - DONE: out_valid=1, x_o/y_o/z_o stable. If out_ready=1, go to IDLE. Otherwise hold indefinitely with outputs unchanged.
- **Latency:** input handshake at edge k → out_valid high after edge k+N_ITERATIONS. Throughput: one result per N_ITERATIONS+2 cycles when out_ready is held at 1.
- **Input-side don't-cares:** in_valid is ignored outside IDLE. Input data may change freely once the handshake has occurred.
- **Direction d per iteration** (d=1 means clockwise):
  - Rotation mode: d = sign bit of current z.
  - Vectoring mode: d = NOT sign bit of current y, i.e. y >= 0 → d=1.
- **Micro-rotation update:**
  - d=1: x' = x + (y>>>i), y' = y - (x>>>i), z' = z + atan_i.
  - d=0: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - atan_i.
  - Shifts are arithmetic. All updates are computed from the pre-update x, y, z of the same cycle.
  - Sums wrap modulo 2^WORD_LENGTH; no saturation.
- **Arctangent ROM:**
  - atan_i = round(atan(2^-i) * 2^FRAC_BITS).
  - Sourced from a 31-entry table held at 30 fractional bits, right-shifted by (30-FRAC_BITS) with round-half-up.
  - The ROM is addressed by the internal counter.
- **Gain:** not compensated. Magnitudes scale by K = prod(sqrt(1+2^-2i)), ≈ 1.64676 for N >= 12. Callers pre-scale by 1/K where required.
- **Convergence domain:**
  - Rotation: |z_i| <= 1.7433 rad.
  - Vectoring: x_i > 0.
  - Outside these domains results are unspecified but must not hang the FSM.
- **Reporting:** no $display in synthesised paths.
- **Elaboration checks:** parameter violations trigger a $error at elaboration.

Test Plan:
- **Rotation, pi/4:** mode=0, x=39797 (1/K), y=0, z=51472 (pi/4) → x_o and y_o = 46341 ±8 LSB, z_o = 0 ±4, out_valid exactly 17 cycles after the handshake.
- **Vectoring, 45 degrees:** mode=1, x=65536, y=65536, z=0 → x_o = 152626 ±16, y_o = 0 ±8, z_o = 51472 ±4.
- **Rotation, negative angle:** mode=0, x=39797, y=0, z=-102944 (-pi/2) → x_o = 0 ±8, y_o = -65536 ±8. Sign handling is correct throughout.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid → outputs and out_valid stable, in_ready=0, and a new in_valid pulse during this window is ignored. Then out_ready=1 → IDLE next edge, and the next operation is accepted.
- **Reset mid-RUN:** drive rst=0 at iteration 5 → next edge: out_valid=0, outputs zero, in_ready=1. No stale result appears afterwards.
- **Parameter sweep:** WORD_LENGTH=16, FRAC_BITS=12, N_ITERATIONS=12 → rotation pi/6 (z=2145, x=2487) gives x_o = 3547 ±4, y_o = 2048 ±4, latency 12 cycles. Results checked against a real-valued reference model.
